// File: rtl/mem_fifo_loader.sv
// rtl/mem_fifo_loader.sv - Avalon-MM row fetcher that unpacks words into per-row input FIFOs
// Loads NUM_ROWS words (matrix A rows, then vector B) and signals done when all FIFOs are filled.
module mem_fifo_loader #(
  parameter int          DATA_WIDTH = 8,
  parameter int          WORD_WIDTH = 64,
  parameter int          NUM_ROWS   = 9,
  parameter int          ADDR_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  read,
  input  logic [WORD_WIDTH-1:0] readdata,
  input  logic                  readdatavalid,
  input  logic                  waitrequest,
  input  logic [NUM_ROWS-1:0]   fifo_full,
  output logic [NUM_ROWS-1:0]   fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int ELEMS = WORD_WIDTH / DATA_WIDTH;
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, UNPACK, NEXT, DONE} state_t;

  state_t                  state, state_next;
  logic [ROW_W-1:0]        row, row_next;
  logic [IDX_W-1:0]        idx, idx_next;
  logic [WORD_WIDTH-1:0]   word, word_next;
  logic [WORD_WIDTH-1:0]   word_shifted;
  logic                    row_ready;

  // Most-significant element first: shift the current element to the top of the word.
  assign word_shifted = word << (DATA_WIDTH * int'(idx));
  assign row_ready    = !fifo_full[row];

  always_comb begin
    state_next = state;
    row_next   = row;
    idx_next   = idx;
    word_next  = word;
    fifo_wr_en = '0;
    fifo_wdata = word_shifted[WORD_WIDTH-1 -: DATA_WIDTH];
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = REQ;
          row_next   = '0;
        end
      end
      REQ: begin
        if (!waitrequest) state_next = WAIT;
      end
      WAIT: begin
        if (readdatavalid) begin
          word_next  = readdata;
          idx_next   = '0;
          state_next = UNPACK;
        end
      end
      UNPACK: begin
        // Write enable is gated by the live full flag so a write never lands on a full FIFO.
        if (row_ready) begin
          fifo_wr_en = NUM_ROWS'(1) << row;
          idx_next   = idx + 1'b1;
          if (idx == LAST_IDX) state_next = NEXT;
        end
      end
      NEXT: begin
        if (row == LAST_ROW) begin
          state_next = DONE;
        end else begin
          row_next   = row + 1'b1;
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      idx     <= '0;
      word    <= '0;
      address <= '0;
      read    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      row   <= row_next;
      idx   <= idx_next;
      word  <= word_next;
      // Bus and status outputs are registered from the next state so they align with it.
      read  <= (state_next == REQ);
      busy  <= (state_next == REQ) || (state_next == WAIT) ||
               (state_next == UNPACK) || (state_next == NEXT);
      done  <= (state_next == DONE);
      if (state_next == REQ) address <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(row_next);
    end
  end

endmodule

// File: tb/tb_mem_fifo_loader.sv
// tb/tb_mem_fifo_loader.sv - directed self-checking bench for mem_fifo_loader
module tb_mem_fifo_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] address;
  logic        read;
  logic [63:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic [8:0]  fifo_full;
  logic [8:0]  fifo_wr_en;
  logic [7:0]  fifo_wdata;
  logic        busy;
  logic        done;

  mem_fifo_loader dut (
    .clk(clk), .rst(rst), .start(start), .address(address), .read(read),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  initial forever #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0] mem [0:15];
  logic        inject = 1'b0;
  logic        ws_enable = 1'b0;

  int          cyc = 0;
  int          n_rd = 0, n_rd2 = 0, n_wr = 0, n_done = 0, n_full_wr = 0;
  logic [31:0] rd_addr_log [0:127];
  int          rd_cyc_log [0:127];
  logic [8:0]  wr_en_log [0:1023];
  logic [7:0]  wr_data_log [0:1023];
  int          done_cyc_log [0:63];
  logic        done_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (read && !waitrequest && n_rd < 128) begin
      rd_addr_log[n_rd] = address;
      rd_cyc_log[n_rd] = cyc;
      n_rd++;
    end
    if (read && address == 32'd2) n_rd2++;
    if (fifo_wr_en != 9'd0 && n_wr < 1024) begin
      wr_en_log[n_wr] = fifo_wr_en;
      wr_data_log[n_wr] = fifo_wdata;
      n_wr++;
    end
    if ((fifo_wr_en & fifo_full) != 9'd0) n_full_wr++;
    if (done && !done_q && n_done < 64) begin
      done_cyc_log[n_done] = cyc;
      n_done++;
    end
    done_q = done;
  end

  // Avalon slave: zero wait states by default, 1-cycle read latency.
  logic       acc;
  logic [3:0] acc_addr;
  int         ws_cnt;
  initial begin
    readdatavalid = 1'b0;
    readdata = 64'd0;
    waitrequest = 1'b0;
    ws_cnt = 0;
    forever begin
      @(negedge clk);
      acc = read && !waitrequest;
      acc_addr = address[3:0];
      @(posedge clk);
      #1;
      readdatavalid = (acc && !rst) || inject;
      readdata = inject ? 64'hDEADBEEFCAFEF00D : (acc ? mem[acc_addr] : 64'd0);
      if (!ws_enable) ws_cnt = 0;
      if (ws_enable && read && address == 32'd2 && ws_cnt < 3) begin
        waitrequest = 1'b1;
        ws_cnt++;
      end else begin
        waitrequest = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int k = 0;
    while (n_done <= base && k < 400) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(n_done > base), 64'd1);
  endtask

  task automatic wait_writes(input int target, input string tag);
    int k = 0;
    while (n_wr < target && k < 400) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(n_wr >= target), 64'd1);
  endtask

  task automatic check_load(input int bw, input int br, input string tag);
    logic [63:0] w;
    logic [7:0]  e;
    chk({tag, "_nwr"}, 64'(n_wr - bw), 64'd72);
    chk({tag, "_nrd"}, 64'(n_rd - br), 64'd9);
    for (int r = 0; r < 9; r++)
      chk($sformatf("%s_addr%0d", tag, r), 64'(rd_addr_log[br + r]), 64'(r));
    for (int k = 0; k < 72; k++) begin
      w = mem[k / 8];
      e = 8'((w >> (56 - 8 * (k % 8))) & 64'hFF);
      chk($sformatf("%s_en%0d", tag, k), 64'(wr_en_log[bw + k]), 64'(9'd1 << (k / 8)));
      chk($sformatf("%s_data%0d", tag, k), 64'(wr_data_log[bw + k]), 64'(e));
    end
  endtask

  int bw, br, bd, b2, w0;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    fifo_full = 9'd0;
    for (int r = 0; r < 16; r++) mem[r] = {8{8'(r + 1)}};

    // Reset then idle
    tick(2);
    chk("reset_outs", {address, read, fifo_wr_en, fifo_wdata, busy, done}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk($sformatf("idle_outs%0d", i), {address, read, fifo_wr_en, fifo_wdata, busy, done}, 64'd0);
    end
    chk("idle_no_reads", 64'(n_rd), 64'd0);

    // Nominal load
    bw = n_wr; br = n_rd; bd = n_done;
    pulse_start();
    chk("nom_busy", 64'(busy), 64'd1);
    chk("nom_read", 64'(read), 64'd1);
    chk("nom_addr0", 64'(address), 64'd0);
    wait_done(bd, "nom_done_timeout");
    check_load(bw, br, "nom");
    chk("nom_latency", 64'(done_cyc_log[bd] - rd_cyc_log[br]), 64'd99);
    chk("nom_status", {62'd0, busy, done}, 64'd1);

    // Byte order, wait states on row 2, FIFO4 stall
    mem[0] = 64'h0102030405060708;
    ws_enable = 1'b1;
    bw = n_wr; br = n_rd; bd = n_done; b2 = n_rd2;
    pulse_start();
    wait_writes(bw + 35, "stall_reach");
    fifo_full = 9'h011;
    w0 = n_wr;
    tick(5);
    chk("stall_no_writes", 64'(n_wr), 64'(w0));
    fifo_full = 9'd0;
    wait_done(bd, "ws_done_timeout");
    ws_enable = 1'b0;
    check_load(bw, br, "ws");
    for (int i = 0; i < 8; i++)
      chk($sformatf("byte_order%0d", i), 64'(wr_data_log[bw + i]), 64'(i + 1));
    chk("ws_read_hold", 64'(n_rd2 - b2), 64'd4);
    chk("full_violations", 64'(n_full_wr), 64'd0);
    chk("ws_latency", 64'(done_cyc_log[bd] - rd_cyc_log[br]), 64'd107);

    // Start while busy is ignored; start after done reloads
    bw = n_wr; br = n_rd; bd = n_done;
    pulse_start();
    tick(19);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(bd, "busy_done_timeout");
    check_load(bw, br, "busy");
    chk("busy_latency", 64'(done_cyc_log[bd] - rd_cyc_log[br]), 64'd99);
    tick(3);
    chk("done_level", 64'(done), 64'd1);
    bw = n_wr; br = n_rd; bd = n_done;
    pulse_start();
    chk("restart_done_clr", 64'(done), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_done(bd, "restart_done_timeout");
    check_load(bw, br, "restart");

    // Reset during row 5 unpack
    bw = n_wr;
    pulse_start();
    wait_writes(bw + 42, "row5_reach");
    rst = 1'b1;
    #1;
    chk("rst_outs", {read, fifo_wr_en, busy, done}, 64'd0);
    w0 = n_wr;
    tick(3);
    chk("rst_no_writes", 64'(n_wr), 64'(w0));
    rst = 1'b0;
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    tick(1);
    chk("stray_rdv", {fifo_wdata, read, busy, done}, 64'd0);
    chk("stray_no_writes", 64'(n_wr), 64'(w0));
    bw = n_wr; br = n_rd; bd = n_done;
    pulse_start();
    wait_done(bd, "reload_done_timeout");
    check_load(bw, br, "reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
